// File: rtl/spi_response_arbiter_if.sv
// spi_response_arbiter_if: host/SPI/result handshakes and the shift-register load bus
//   slave  : arbiter side (SPI strobes, commands and results in; load bus, cost_req, resp_done, busy, status out)
//   master : environment side (mirror of slave)
interface spi_response_arbiter_if;
  logic       shift_SPI;
  logic       SS;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       digit_valid;
  logic [3:0] digit;
  logic       cost_valid;
  logic [7:0] cost;
  logic       load_en;
  logic [7:0] load_data;
  logic       cost_req;
  logic       resp_done;
  logic       busy;
  logic [3:0] status;
  modport slave (
    input  shift_SPI, SS, cmd_valid, cmd_byte, digit_valid, digit, cost_valid, cost,
    output load_en, load_data, cost_req, resp_done, busy, status
  );
  modport master (
    output shift_SPI, SS, cmd_valid, cmd_byte, digit_valid, digit, cost_valid, cost,
    input  load_en, load_data, cost_req, resp_done, busy, status
  );
endinterface

// File: rtl/spi_response_arbiter.sv
// spi_response_arbiter: picks the next SPI response byte (COST > DIGIT > STATUS) and feeds the output shift register
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave modport of spi_response_arbiter_if
module spi_response_arbiter #(
  parameter logic [7:0] IDLE_BYTE     = 8'hFF,
  parameter int         TIMEOUT_BYTES = 4
) (
  input logic                    clk,
  input logic                    rst,
  spi_response_arbiter_if.slave  bus
);
  localparam int WW = $clog2(TIMEOUT_BYTES + 1);
  typedef enum logic [1:0] {IDLE, WAIT_COST, LOAD, SEND} state_t;
  typedef enum logic [1:0] {SEL_STATUS, SEL_DIGIT, SEL_COST} sel_t;
  state_t          state_q, state_d;
  sel_t            sel_q, sel_d;
  logic [2:0]      cnt_q;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            dig_pend_q, cost_pend_q, overrun_q, timeout_q, cost_query_q;
  logic [3:0]      dig_q;
  logic [7:0]      cost_q;
  logic            cost_req_q, resp_done_q;
  logic            byte_done, flush, query, done_cost, done_digit, tmo;
  logic [3:0]      status_w;
  assign byte_done     = bus.shift_SPI && !bus.SS && cnt_q == 3'd7;
  assign flush         = bus.cmd_valid && bus.cmd_byte == 8'h02;
  assign query         = bus.cmd_valid && bus.cmd_byte == 8'h01;
  assign status_w      = {dig_pend_q, cost_pend_q, overrun_q, timeout_q};
  assign bus.status    = status_w;
  assign bus.busy      = state_q != IDLE;
  assign bus.cost_req  = cost_req_q;
  assign bus.resp_done = resp_done_q;
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    wcnt_d        = wcnt_q;
    bus.load_en   = 1'b0;
    bus.load_data = IDLE_BYTE;
    done_cost     = 1'b0;
    done_digit    = 1'b0;
    tmo           = 1'b0;
    case (state_q)
      IDLE: begin
        bus.load_en = 1'b1;
        wcnt_d      = '0;
        // decide only at a byte boundary of an active session
        if (!bus.SS && cnt_q == 3'd0) begin
          state_d = (cost_query_q && !cost_pend_q) ? WAIT_COST : LOAD;
          sel_d   = cost_query_q ? SEL_COST : dig_pend_q ? SEL_DIGIT : SEL_STATUS;
        end
      end
      WAIT_COST: begin
        bus.load_en = byte_done;
        if (bus.cost_valid) begin
          state_d = LOAD;
          sel_d   = SEL_COST;
        end else if (byte_done) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WW'(TIMEOUT_BYTES - 1)) begin
            tmo     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      LOAD: begin
        bus.load_en   = 1'b1;
        bus.load_data = sel_q == SEL_COST ? cost_q : sel_q == SEL_DIGIT ? {4'h0, dig_q} : {4'hA, status_w};
        state_d       = SEND;
      end
      default: begin
        if (byte_done) begin
          done_cost  = sel_q == SEL_COST;
          done_digit = sel_q == SEL_DIGIT;
          state_d    = IDLE;
        end
      end
    endcase
    // deselect aborts whatever is in flight; flags and data are kept so the byte is resent
    if (bus.SS) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= SEL_STATUS;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      dig_pend_q   <= 1'b0;
      cost_pend_q  <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      cost_query_q <= 1'b0;
      dig_q        <= '0;
      cost_q       <= '0;
      cost_req_q   <= 1'b0;
      resp_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      wcnt_q       <= wcnt_d;
      cnt_q        <= bus.SS ? 3'd0 : bus.shift_SPI ? cnt_q + 3'd1 : cnt_q;
      if (bus.digit_valid) dig_q <= bus.digit;
      if (bus.cost_valid) cost_q <= bus.cost;
      // set terms win over same-cycle clears
      dig_pend_q   <= bus.digit_valid || (dig_pend_q && !flush && !done_digit);
      overrun_q    <= (bus.digit_valid && dig_pend_q) || (overrun_q && !flush);
      cost_pend_q  <= bus.cost_valid || (cost_pend_q && !flush && !done_cost);
      cost_query_q <= query || (cost_query_q && !flush && !done_cost && !tmo);
      timeout_q    <= tmo || (timeout_q && !flush);
      cost_req_q   <= state_q == IDLE && state_d == WAIT_COST;
      resp_done_q  <= state_q == SEND && byte_done;
    end
  end
endmodule

// File: tb/tb_spi_response_arbiter.sv
// tb_spi_response_arbiter: directed checks of response selection, cost wait/timeout, abort and reset
module tb_spi_response_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int cr_cnt = 0;
  int rd0;
  logic [7:0] last_load = 8'h00;
  logic [7:0] b;
  spi_response_arbiter_if bus();
  spi_response_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // host-side shift register: remembers the last loaded byte; count output pulses
  always @(posedge clk) begin
    if (bus.load_en) last_load <= bus.load_data;
    if (bus.resp_done) rd_cnt <= rd_cnt + 1;
    if (bus.cost_req) cr_cnt <= cr_cnt + 1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic shifts(input int n);
    for (int i = 0; i < n; i++) begin
      bus.shift_SPI = 1'b1;
      tick;
      bus.shift_SPI = 1'b0;
      repeat (3) tick;
    end
  endtask
  task automatic send_byte(output logic [7:0] v);
    repeat (3) tick;
    v = last_load;
    shifts(8);
  endtask
  task automatic cmd(input logic [7:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = c;
    tick;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic dig(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    tick;
    bus.digit_valid = 1'b0;
  endtask
  task automatic cst(input logic [7:0] c);
    bus.cost_valid = 1'b1;
    bus.cost       = c;
    tick;
    bus.cost_valid = 1'b0;
  endtask
  task automatic deselect;
    bus.SS = 1'b1;
    repeat (2) tick;
  endtask
  initial begin
    bus.shift_SPI = 1'b0; bus.SS = 1'b1; bus.cmd_valid = 1'b0; bus.cmd_byte = 8'h00;
    bus.digit_valid = 1'b0; bus.digit = 4'h0; bus.cost_valid = 1'b0; bus.cost = 8'h00;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk("rst_load_en", 32'(bus.load_en), 32'h1);
    chk("rst_load_data", 32'(bus.load_data), 32'hFF);
    chk("rst_status", 32'(bus.status), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_flags_out", 32'({bus.cost_req, bus.resp_done}), 32'h0);
    // digit response
    dig(4'h7);
    chk("dig_pend_set", 32'(bus.status), 32'h8);
    rd0 = rd_cnt;
    bus.SS = 1'b0;
    send_byte(b);
    chk("digit_byte", 32'(b), 32'h07);
    chk("digit_resp_done", 32'(rd_cnt), 32'(rd0 + 1));
    chk("digit_pend_clr", 32'(bus.status), 32'h0);
    deselect;
    // ignored command
    cmd(8'h03);
    chk("cmd_ignored", 32'(bus.status), 32'h0);
    // cost query answered during byte 2
    cmd(8'h01);
    rd0 = rd_cnt;
    bus.SS = 1'b0;
    send_byte(b);
    chk("wait_byte1", 32'(b), 32'hFF);
    chk("wait_busy", 32'(bus.busy), 32'h1);
    cst(8'h5C);
    send_byte(b);
    chk("cost_byte2", 32'(b), 32'h5C);
    chk("cost_req_once", 32'(cr_cnt), 32'h1);
    chk("cost_resp_done", 32'(rd_cnt), 32'(rd0 + 1));
    chk("cost_pend_clr", 32'(bus.status), 32'h0);
    deselect;
    // cost query that times out
    cmd(8'h01);
    bus.SS = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_byte(b);
      chk("timeout_fill", 32'(b), 32'hFF);
    end
    chk("timeout_flag", 32'(bus.status), 32'h1);
    send_byte(b);
    chk("timeout_status_byte", 32'(b), 32'hA1);
    chk("timeout_cost_req", 32'(cr_cnt), 32'h2);
    deselect;
    cmd(8'h02);
    chk("flush_timeout", 32'(bus.status), 32'h0);
    // overrun
    dig(4'h3);
    dig(4'h9);
    chk("overrun_status", 32'(bus.status), 32'hA);
    bus.SS = 1'b0;
    send_byte(b);
    chk("overrun_byte", 32'(b), 32'h09);
    chk("overrun_sticky", 32'(bus.status), 32'h2);
    deselect;
    cmd(8'h02);
    chk("flush_overrun", 32'(bus.status), 32'h0);
    // priority: cost before digit
    cst(8'h33);
    dig(4'h5);
    cmd(8'h01);
    chk("prio_status", 32'(bus.status), 32'hC);
    bus.SS = 1'b0;
    send_byte(b);
    chk("prio_first_cost", 32'(b), 32'h33);
    send_byte(b);
    chk("prio_second_digit", 32'(b), 32'h05);
    chk("prio_clear", 32'(bus.status), 32'h0);
    deselect;
    // abort mid-byte and resend
    dig(4'h6);
    rd0 = rd_cnt;
    bus.SS = 1'b0;
    repeat (3) tick;
    shifts(4);
    deselect;
    chk("abort_no_resp", 32'(rd_cnt), 32'(rd0));
    chk("abort_pend_kept", 32'(bus.status), 32'h8);
    chk("abort_idle", 32'(bus.busy), 32'h0);
    bus.SS = 1'b0;
    send_byte(b);
    chk("abort_resend", 32'(b), 32'h06);
    chk("abort_resend_done", 32'(rd_cnt), 32'(rd0 + 1));
    deselect;
    // reset in SEND on the final shift
    dig(4'h4);
    rd0 = rd_cnt;
    bus.SS = 1'b0;
    repeat (3) tick;
    shifts(7);
    rst = 1'b1;
    bus.shift_SPI = 1'b1;
    tick;
    rst = 1'b0;
    bus.shift_SPI = 1'b0;
    bus.SS = 1'b1;
    repeat (2) tick;
    chk("rst_send_no_resp", 32'(rd_cnt), 32'(rd0));
    chk("rst_send_status", 32'(bus.status), 32'h0);
    chk("rst_send_load", 32'({bus.load_en, bus.load_data}), 32'h1FF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_response_arbiter.md
SPI_RESPONSE_ARBITER -- requirements
Module: spi_response_arbiter

Interface
REQ-001 Parameter IDLE_BYTE, default 8'hFF, byte driven to the output shift register while no response is owned.
REQ-002 Parameter TIMEOUT_BYTES, default 4, number of host byte times allowed in WAIT_COST before giving up.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 shift_SPI  input  1  one-cycle pulse per SCK bit slot consumed by the host.
REQ-006 SS  input  1  active-low slave select.
REQ-007 cmd_valid  input  1  one-cycle pulse, cmd_byte holds a complete host command.
REQ-008 cmd_byte  input  8  host command: 8'h01 = cost query, 8'h02 = flush, all other values ignored.
REQ-009 digit_valid  input  1  one-cycle pulse, network result on digit.
REQ-010 digit  input  4  detected digit.
REQ-011 cost_valid  input  1  one-cycle pulse, cost result on cost.
REQ-012 cost  input  8  cost value.
REQ-013 load_en  output  1  load strobe to the output parallel-to-serial shift register.
REQ-014 load_data  output  8  byte to load.
REQ-015 cost_req  output  1  one-cycle request to the cost unit.
REQ-016 resp_done  output  1  one-cycle pulse when a response byte completes.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 status  output  4  {dig_pend, cost_pend, overrun, timeout}.

Function
REQ-019 3-bit bit counter shall increment on shift_SPI while SS=0, wrap 7->0, and byte_done shall be shift_SPI while the count is 7; SS=1 shall clear the counter.
REQ-020 digit_valid shall capture digit and set dig_pend; if dig_pend is already 1, overrun shall be set (sticky) and the new digit shall overwrite the old one.
REQ-021 cost_valid shall capture cost and set cost_pend.
REQ-022 When a pending flag is set and cleared in the same cycle, set shall win and the newly captured data shall be retained.
REQ-023 cmd 8'h01 shall set cost_query; cmd 8'h02 shall clear dig_pend, cost_pend, cost_query, overrun and timeout.
REQ-024 FSM states: IDLE, WAIT_COST, LOAD, SEND.
REQ-025 In IDLE, load_en=1 and load_data=IDLE_BYTE every cycle.
REQ-026 In IDLE with SS=0 and count=0, cost_query=1 and cost_pend=1 shall select COST and go to LOAD.
REQ-027 In IDLE with SS=0 and count=0, cost_query=1 and cost_pend=0 shall go to WAIT_COST.
REQ-028 In IDLE with SS=0 and count=0 and cost_query=0, dig_pend=1 shall select DIGIT and go to LOAD; otherwise the FSM shall select STATUS and go to LOAD.
REQ-029 Priority shall be COST > DIGIT > STATUS.
REQ-030 WAIT_COST: cost_req=1 on the first cycle only, with IDLE_BYTE loaded on every byte boundary.
REQ-031 WAIT_COST: cost_valid shall select COST and go to LOAD.
REQ-032 WAIT_COST: TIMEOUT_BYTES byte_done events without cost_valid shall set timeout (sticky), clear cost_query and return to IDLE.
REQ-033 LOAD shall last exactly one cycle with load_en=1, then go to SEND.
REQ-034 load_data in LOAD: COST -> cost register; DIGIT -> {4'h0, digit register}; STATUS -> {4'hA, status}.
REQ-035 SEND: load_en=0; on byte_done, resp_done=1 for one cycle and the FSM returns to IDLE.
REQ-036 Completing COST shall clear cost_pend and cost_query; completing DIGIT shall clear dig_pend; completing STATUS shall clear nothing.
REQ-037 SS rising in any state shall return the FSM to IDLE within one cycle with no resp_done, and all pending flags and data shall be retained (aborted byte is resent).
REQ-038 Environment guarantee: shift_SPI pulses are at least 4 clk cycles apart, so LOAD completes before the first bit shift.

Reset
REQ-039 rst=1 shall force IDLE, counter 0, and all flags, cost_query, captured data, cost_req and resp_done to 0.
REQ-040 rst mid-SEND shall abort the byte with no resp_done.
REQ-041 On the cycle after reset, load_en=1 and load_data=IDLE_BYTE.

Verification
REQ-042 digit_valid with digit=7, then SS low and 8 shifts -> load_data=8'h07 in LOAD, resp_done after the 8th shift, dig_pend=0.
REQ-043 cmd 8'h01, no cost, cost_valid with cost=8'h5C during byte 2 -> one cost_req pulse, byte 1 is 8'hFF, byte 2 loads 8'h5C, cost_pend=0.
REQ-044 cmd 8'h01 with no cost_valid for 4 bytes -> timeout=1, next byte is STATUS 8'hA1.
REQ-045 Two digit_valid pulses (3 then 9) before any SPI traffic -> overrun=1, sent byte is 8'h09, flush (8'h02) -> status=4'h0.
REQ-046 cost_pend and dig_pend both set with cost_query=1 -> COST byte first, DIGIT byte second.
REQ-047 SS raised after 4 shifts of a DIGIT byte -> no resp_done, dig_pend=1, next SS-low session resends the digit.
